spi_mem_host_arb: RTL and testbench

//  Two-port SPI host for the 8-bit SPI memory slave (op bit, LSB-first address/data, ready/op_done strobes).

---
 rtl/spi_mem_pkg.sv | 34 +++
 rtl/spi_mem_host_arb_rr_arb2.sv | 42 ++++
 rtl/spi_mem_host_arb.sv | 162 ++++++++++++++++
 tb/tb_spi_mem_host_arb.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the two-port SPI memory host.
// Contents:
//   host_state_t  - host FSM state encoding (3-bit, fixed legacy values)
//   OP_WR/OP_RD   - op bit values sent in the two command cycles
//   WR_BITS       - address+data bits shifted for a write frame
//   RD_ADDR_BITS  - address bits shifted for a read frame
//   RX_BITS       - read data bits captured from miso
//   port_onehot() - turns a 1-bit port index into a 2-bit one-hot strobe
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_GUARD     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_RDY  = 3'd4,
    ST_RX        = 3'd5,
    ST_WAIT_DONE = 3'd6,
    ST_RESP      = 3'd7
  } host_state_t;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  localparam int CMD_BITS     = 2;
  localparam int WR_BITS      = 16;
  localparam int RD_ADDR_BITS = 8;
  localparam int RX_BITS      = 8;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_mem_host_arb_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   req[1:0]   - request per port
//   adv        - a grant was taken this cycle; move priority past it
//   gnt[1:0]   - one-hot grant (zero when no request)
// After reset port0 has priority. With both ports requesting, the port
// that was not granted last wins, so simultaneous requests alternate.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // Index of the most recently granted port.
  logic last_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rstn) begin
      last_q <= 1'b1;
    end else if (adv && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/spi_mem_host_arb.sv
// Two-port SPI host for an 8-bit SPI memory slave.
// Arbitrates two requester ports round-robin, serialises each accepted
// request into one SPI frame (op bit twice, then LSB-first address and,
// for writes, data), captures read data from miso and returns a per-port
// response. Waits for ready/op_done are bounded by TIMEOUT.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   req_valid/req_ready  - per-port handshake; req_ready is a 1-cycle grant
//   req_wr/addr/wdata    - per-port request fields, port p at [p*W +: W]
//   rsp_valid            - per-port 1-cycle response strobe
//   rsp_rdata, rsp_err   - response payload, valid with rsp_valid
//   cs, mosi, miso       - SPI pins (cs active-low)
//   ready, op_done       - slave read-data-ready and completion strobes
module spi_mem_host_arb
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 32,
  parameter int TIMEOUT   = 64,
  parameter int GUARD     = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                cs,
  output logic                mosi,
  input  logic                miso,
  input  logic                ready,
  input  logic                op_done
);

  // One counter serves both the guard interval and the strobe timeouts.
  localparam int CNT_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  host_state_t                state_q, state_d;
  logic [4:0]                 bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]           wait_cnt_q, wait_cnt_d;
  logic                       port_q;
  logic                       wr_q;
  logic [ADDR_W+DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]          rdata_q;
  logic                       err_q;

  logic [1:0]                 gnt;
  logic                       accept;
  logic                       sel_port;
  logic                       sel_wr;
  logic [ADDR_W-1:0]          sel_addr;
  logic [DATA_W-1:0]          sel_wdata;
  logic                       bad_addr;
  logic [4:0]                 shift_last;
  logic                       strobe;
  logic                       timeout_hit;

  rr_arb2 u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req_valid),
    .adv  (accept),
    .gnt  (gnt)
  );

  assign accept    = (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign sel_port  = gnt[1];
  assign sel_wr    = req_wr[sel_port];
  assign sel_addr  = sel_port ? req_addr[2*ADDR_W-1 -: ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = sel_port ? req_wdata[2*DATA_W-1 -: DATA_W] : req_wdata[DATA_W-1:0];
  assign bad_addr  = (32'(sel_addr) >= 32'(MEM_DEPTH));

  // A write frame shifts address then data; a read frame only the address.
  assign shift_last = wr_q ? 5'(WR_BITS - 1) : 5'(RD_ADDR_BITS - 1);

  // The strobe that ends the current wait; anything else is ignored.
  assign strobe      = (state_q == ST_WAIT_RDY) ? ready : op_done;
  assign timeout_hit = (state_q inside {ST_WAIT_RDY, ST_WAIT_DONE}) && !strobe &&
                       (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GUARD:     if (wait_cnt_q == CNT_W'(GUARD - 1))  state_d = ST_IDLE;
      ST_IDLE:      if (accept)                           state_d = bad_addr ? ST_RESP : ST_CMD;
      ST_CMD:       if (bit_cnt_q == 5'(CMD_BITS - 1))    state_d = ST_SHIFT;
      ST_SHIFT:     if (bit_cnt_q == shift_last)          state_d = wr_q ? ST_WAIT_DONE : ST_WAIT_RDY;
      ST_WAIT_RDY:  if (ready)                            state_d = ST_RX;
                    else if (timeout_hit)                 state_d = ST_RESP;
      ST_RX:        if (bit_cnt_q == 5'(RX_BITS - 1))     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (op_done || timeout_hit)           state_d = ST_RESP;
      ST_RESP:                                            state_d = ST_GUARD;
      default:                                            state_d = ST_GUARD;
    endcase
  end

  // Counters restart on every state change, so each phase counts from 0
  // and the bit counter peaks at 15 inside a write's SHIFT phase.
  always_comb begin
    bit_cnt_d  = 5'd0;
    wait_cnt_d = '0;
    if (state_d == state_q) begin
      if (state_q inside {ST_CMD, ST_SHIFT, ST_RX}) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
      if (state_q inside {ST_GUARD, ST_WAIT_RDY, ST_WAIT_DONE}) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_GUARD;
      bit_cnt_q  <= 5'd0;
      wait_cnt_q <= '0;
      port_q     <= 1'b0;
      wr_q       <= 1'b0;
      shift_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            port_q  <= sel_port;
            wr_q    <= sel_wr;
            shift_q <= {sel_wdata, sel_addr};
            // Cleared here so a bad address or an early timeout returns 0.
            rdata_q <= '0;
            err_q   <= bad_addr;
          end
        end
        ST_SHIFT:     shift_q <= shift_q >> 1;
        ST_RX:        rdata_q <= {miso, rdata_q[DATA_W-1:1]};
        ST_WAIT_RDY,
        ST_WAIT_DONE: if (timeout_hit) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // cs is low only while bits are being driven, so it is already high
  // when the slave returns to idle and re-samples it.
  assign cs        = !(state_q inside {ST_CMD, ST_SHIFT});
  assign mosi      = (state_q == ST_CMD)   ? (wr_q ? OP_WR : OP_RD) :
                     (state_q == ST_SHIFT) ? shift_q[0] : 1'b0;
  assign req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;
  assign rsp_valid = (state_q == ST_RESP) ? port_onehot(port_q) : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_spi_mem_host_arb.sv
// Self-checking bench for spi_mem_host_arb with a behavioural SPI memory
// slave. Accepted requests push an expected response (and, for legal
// addresses, an expected frame) to scoreboard queues; the monitor pops
// them when a frame ends or a response appears.
module tb_spi_mem_host_arb;
  import spi_mem_pkg::*;

  localparam int TIMEOUT   = 64;
  localparam int GUARD_CYC = 4;
  localparam int MEM_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr = 2'b00;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        cs;
  logic        mosi;
  logic        miso = 1'b0;
  logic        ready = 1'b0;
  logic        op_done = 1'b0;

  always #5 clk = ~clk;

  spi_mem_host_arb #(
    .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT), .GUARD(GUARD_CYC)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cs(cs), .mosi(mosi), .miso(miso), .ready(ready), .op_done(op_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         port;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
    bit         err;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } frame_t;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  exp_t       sb[$];
  frame_t     fq[$];
  req_t       pq0[$];
  req_t       pq1[$];
  int         grant_log[$];
  logic [7:0] ref_mem [0:255];
  logic [7:0] smem    [0:255];
  bit         dead = 1'b0;

  // Slave model state.
  bit         s_act = 1'b0;
  bit         s_low_done = 1'b0;
  int         s_t = 0;
  int         s_gap = 0;
  logic       s_op0 = 1'b0;
  logic       s_op1 = 1'b0;
  logic [7:0] s_addr = 8'h0;
  logic [7:0] s_data = 8'h0;

  function automatic req_t mk(input bit wr, input logic [7:0] addr, input logic [7:0] data);
    req_t r;
    r.wr = wr; r.addr = addr; r.data = data;
    return r;
  endfunction

  task automatic on_accept(input int p);
    exp_t   e;
    frame_t f;
    bit     bad;
    e.port = p;
    e.wr   = req_wr[p];
    e.addr = req_addr[p*8 +: 8];
    e.data = req_wdata[p*8 +: 8];
    bad    = (e.addr >= MEM_DEPTH);
    e.err  = bad || dead;
    e.rdata = (bad || dead || e.wr) ? 8'h00 : ref_mem[e.addr];
    e.lat  = bad ? 1 : dead ? (e.wr ? 19 + TIMEOUT : 11 + TIMEOUT) : (e.wr ? 21 : 23);
    e.acc  = cyc;
    sb.push_back(e);
    if (!bad) begin
      f.wr = e.wr; f.addr = e.addr; f.data = e.data;
      fq.push_back(f);
    end
    grant_log.push_back(p);
  endtask

  task automatic load(input int p);
    req_t r;
    if (p == 0 ? pq0.size() > 0 : pq1.size() > 0) begin
      r = (p == 0) ? pq0.pop_front() : pq1.pop_front();
      req_valid[p]       = 1'b1;
      req_wr[p]          = r.wr;
      req_addr[p*8 +: 8] = r.addr;
      req_wdata[p*8 +: 8] = r.data;
    end else begin
      req_valid[p] = 1'b0;
    end
  endtask

  // Present queued requests on both ports until every one is accepted.
  task automatic run_reqs(input int budget);
    bit a0, a1;
    @(posedge clk); #1;
    load(0);
    load(1);
    while (req_valid != 2'b00 && budget > 0) begin
      @(negedge clk);
      budget--;
      a0 = req_valid[0] && req_ready[0];
      a1 = req_valid[1] && req_ready[1];
      if (a0) on_accept(0);
      if (a1) on_accept(1);
      @(posedge clk); #1;
      if (a0) load(0);
      if (a1) load(1);
    end
    check("req_all_accepted", {30'd0, req_valid}, 32'd0);
  endtask

  task automatic drain(input int budget);
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("rsp_drained", sb.size(), 0);
  endtask

  // Response checker plus SPI memory slave, both evaluated mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t   e;
    frame_t f;
    if (!rstn) begin
      s_act   = 1'b0;
      s_gap   = 0;
      ready   = 1'b0;
      op_done = 1'b0;
      miso    = 1'b0;
    end else begin
      if (rsp_valid != 2'b00) begin
        check("rsp_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_port", rsp_valid, 32'(2'b01 << e.port));
          check("rsp_err", rsp_err, e.err);
          if (!e.wr) check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_latency", cyc - e.acc, e.lat);
          if (e.wr && !e.err) ref_mem[e.addr] = e.data;
        end
      end

      if (!s_act && !cs) begin
        check("guard_gap", s_gap >= GUARD_CYC, 1);
        s_act = 1'b1; s_t = 0; s_low_done = 1'b0; s_addr = 8'h0; s_data = 8'h0;
      end else if (s_act) begin
        s_t++;
      end
      if (cs) s_gap++;
      else    s_gap = 0;

      ready   = 1'b0;
      op_done = 1'b0;
      miso    = 1'b0;
      if (s_act) begin
        if (!cs && !s_low_done) begin
          if (s_t == 0)       s_op0 = mosi;
          else if (s_t == 1)  s_op1 = mosi;
          else if (s_t < 10)  s_addr[s_t-2] = mosi;
          else if (s_t < 18)  s_data[s_t-10] = mosi;
        end else if (cs && !s_low_done) begin
          s_low_done = 1'b1;
          check("frame_expected", fq.size() > 0, 1);
          if (fq.size() > 0) begin
            f = fq.pop_front();
            check("frame_op_t0", s_op0, f.wr);
            check("frame_op_t1", s_op1, f.wr);
            check("frame_addr", s_addr, f.addr);
            if (f.wr) check("frame_wdata", s_data, f.data);
            check("frame_cs_low_cycles", s_t, f.wr ? 18 : 10);
          end
        end
        if (!dead) begin
          if (s_op0 == OP_WR) begin
            if (s_t == 18 && s_low_done) smem[s_addr] = s_data;
            op_done = (s_t == 19);
          end else begin
            ready = (s_t == 11);
            if (s_t >= 12 && s_t <= 19) miso = smem[s_addr][s_t-12];
            op_done = (s_t == 21);
          end
        end
        if (s_t >= 21) begin
          if (!s_low_done) check("cs_stuck_low", cs, 1);
          s_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int budget;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      smem[i]    = 8'h00;
    end

    // Reset values.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_mosi", mosi, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    rstn = 1'b1;

    // 1. Port0 write addr 5 <- 0xA5.
    pq0.push_back(mk(1'b1, 8'd5, 8'hA5));
    run_reqs(200);
    drain(200);

    // 2. Port1 read addr 5.
    pq1.push_back(mk(1'b0, 8'd5, 8'h00));
    run_reqs(200);
    drain(200);

    // 3. Both ports busy: port0 writes, port1 reads back, grants alternate.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      pq0.push_back(mk(1'b1, 8'(10 + i), 8'(8'h30 + i * 17)));
      pq1.push_back(mk(1'b0, 8'(10 + i), 8'h00));
    end
    run_reqs(2000);
    drain(200);
    check("grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) check("grant_order", grant_log[i], i % 2);

    // 4. Bad addresses (40, 32) and the last legal address (31).
    pq0.push_back(mk(1'b0, 8'd40, 8'h00));
    pq0.push_back(mk(1'b1, 8'd31, 8'h5A));
    pq1.push_back(mk(1'b1, 8'd32, 8'h77));
    pq1.push_back(mk(1'b0, 8'd31, 8'h00));
    run_reqs(1000);
    drain(200);

    // 5. Silent slave: write and read both time out, then recovery.
    dead = 1'b1;
    pq0.push_back(mk(1'b1, 8'd7, 8'h3C));
    pq1.push_back(mk(1'b0, 8'd5, 8'h00));
    run_reqs(1000);
    drain(500);
    dead = 1'b0;
    pq0.push_back(mk(1'b0, 8'd5, 8'h00));
    pq1.push_back(mk(1'b0, 8'd7, 8'h00));
    run_reqs(1000);
    drain(200);

    // 6. Reset during T8 of a write, then a fresh request.
    pq0.push_back(mk(1'b1, 8'd20, 8'h55));
    run_reqs(200);
    budget = 60;
    while (!(s_act && s_t == 8) && budget > 0) begin
      @(negedge clk); #2;
      budget--;
    end
    check("abort_at_t8", s_t, 8);
    rstn = 1'b0;
    #1;
    check("abort_cs_high", cs, 1);
    check("abort_mosi", mosi, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_req_ready", req_ready, 0);
    sb.delete();
    fq.delete();
    repeat (3) @(negedge clk);
    check("abort_hold_rsp_valid", rsp_valid, 0);
    rstn = 1'b1;
    pq1.push_back(mk(1'b1, 8'd21, 8'h66));
    run_reqs(200);
    drain(200);
    pq0.push_back(mk(1'b0, 8'd21, 8'h00));
    pq1.push_back(mk(1'b0, 8'd20, 8'h00));
    run_reqs(1000);
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
